// File: rtl/scope_pkg.sv
// Shared constants, capture FSM encoding and sample-to-row mapping for the
// scope trace path.
package scope_pkg;

  localparam logic [10:0] X_START      = 11'd140;
  localparam logic [10:0] N_COLS       = 11'd1000;
  localparam logic [10:0] Y_TOP        = 11'd48;
  localparam logic [10:0] Y_BOT        = 11'd624;
  localparam logic [10:0] Y_CENTER     = 11'd336;
  localparam logic [15:0] TRIG_TIMEOUT = 16'd2048;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    FULL      = 2'd3
  } cap_state_t;

  // Sample 0 sits at the bottom of the trace, 255 at the top (591..81).
  function automatic logic [10:0] sample_to_y(input logic [7:0] s);
    return Y_CENTER + 11'd255 - {2'b00, s, 1'b0};
  endfunction

endpackage

// File: rtl/wave_ram.sv
// Two-bank sample store: one bank is written by the capture FSM while the
// other is read by the display path, with a registered (1-cycle) read.
module wave_ram (
  input  logic       pixel_clk,
  input  logic       we,
  input  logic       wr_bank,
  input  logic [9:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       rd_bank,
  input  logic [9:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [0:2047];

  // NOTE: the array has no reset on purpose; a reset would block RAM
  // inference, and disp_valid already hides stale contents.
  always_ff @(posedge pixel_clk) begin
    if (we) mem[{wr_bank, wr_addr}] <= wr_data;
    rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: rtl/wave_trace_gen.sv
// Captures decimated generator samples into a ping-pong buffer behind an
// edge/auto trigger and flags the pixels lying on the displayed trace.
module wave_trace_gen
  import scope_pkg::*;
(
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  input  logic [7:0]  trig_level,
  input  logic [7:0]  decim,
  input  logic        run,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  output logic        pixel_flag,
  output logic        trig_auto,
  output logic        cap_busy
);

  cap_state_t  state, state_nxt;
  logic [7:0]  dec_cnt;
  logic [7:0]  prev_samp;
  logic        prev_valid;
  logic [15:0] tmo_cnt;
  logic [9:0]  wr_idx;
  logic        bank_sel;
  logic        disp_valid;
  logic [10:0] prev_y;

  logic        accept, frame_start, edge_hit, tmo_hit;
  logic        ram_we, start_cap, swap, enter_wait;
  logic [9:0]  ram_waddr;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [10:0] cur_y, seg_prev, seg_lo, seg_hi;

  assign accept      = data_valid && (dec_cnt == decim);
  assign frame_start = (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);
  assign edge_hit    = prev_valid && (prev_samp < trig_level) && (data_in >= trig_level);
  assign tmo_hit     = (tmo_cnt == TRIG_TIMEOUT - 16'd1);

  always_ff @(posedge pixel_clk) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    ram_we     = 1'b0;
    ram_waddr  = wr_idx;
    start_cap  = 1'b0;
    swap       = 1'b0;
    enter_wait = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          state_nxt  = WAIT_TRIG;
          enter_wait = 1'b1;
        end
      end
      WAIT_TRIG: begin
        if (!run) begin
          state_nxt = IDLE;
        end else if (accept && (edge_hit || tmo_hit)) begin
          state_nxt = CAPTURE;
          ram_we    = 1'b1;
          ram_waddr = 10'd0;
          start_cap = 1'b1;
        end
      end
      CAPTURE: begin
        if (!run) begin
          state_nxt = IDLE;
        end else if (accept) begin
          ram_we = 1'b1;
          if ({1'b0, wr_idx} == N_COLS - 11'd1) state_nxt = FULL;
        end
      end
      FULL: begin
        // The swap happens even when run has dropped, then the trace freezes.
        if (frame_start) begin
          swap = 1'b1;
          if (run) begin
            state_nxt  = WAIT_TRIG;
            enter_wait = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the values from before this clock edge.
  always_ff @(posedge pixel_clk) begin
    if (!sys_rst_n) begin
      dec_cnt    <= '0;
      prev_samp  <= '0;
      prev_valid <= 1'b0;
      tmo_cnt    <= '0;
      wr_idx     <= '0;
      bank_sel   <= 1'b0;
      disp_valid <= 1'b0;
      trig_auto  <= 1'b0;
      prev_y     <= '0;
    end else begin
      if (data_valid) dec_cnt <= (dec_cnt == decim) ? 8'd0 : dec_cnt + 8'd1;

      if (enter_wait) begin
        tmo_cnt    <= '0;
        prev_valid <= 1'b0;
      end else if (state == WAIT_TRIG && accept) begin
        tmo_cnt    <= tmo_cnt + 16'd1;
        prev_samp  <= data_in;
        prev_valid <= 1'b1;
      end

      if (start_cap) begin
        wr_idx    <= 10'd1;
        trig_auto <= !edge_hit;
      end else if (ram_we) begin
        wr_idx <= wr_idx + 10'd1;
      end

      if (swap) begin
        bank_sel   <= ~bank_sel;
        disp_valid <= 1'b1;
      end

      prev_y <= cur_y;
    end
  end

  // Fetch one column ahead so the registered read lands on the current column.
  assign rd_addr = 10'(pixel_xpos + 11'd1 - X_START);

  wave_ram u_ram (
    .pixel_clk (pixel_clk),
    .we        (ram_we),
    .wr_bank   (~bank_sel),
    .wr_addr   (ram_waddr),
    .wr_data   (data_in),
    .rd_bank   (bank_sel),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  assign cur_y    = sample_to_y(rd_data);
  assign seg_prev = (pixel_xpos == X_START) ? cur_y : prev_y;
  assign seg_lo   = (seg_prev < cur_y) ? seg_prev : cur_y;
  assign seg_hi   = (seg_prev < cur_y) ? cur_y : seg_prev;

  assign pixel_flag = disp_valid
                   && (pixel_xpos >= X_START) && (pixel_xpos < X_START + N_COLS)
                   && (pixel_ypos >= Y_TOP) && (pixel_ypos <= Y_BOT)
                   && (pixel_ypos >= seg_lo) && (pixel_ypos <= seg_hi);

  assign cap_busy = (state == WAIT_TRIG) || (state == CAPTURE);

endmodule

// File: tb/tb_wave_trace_gen.sv
// Directed bench for wave_trace_gen: drives samples and pixel coordinates and
// compares flags/status against hand-computed trace geometry.
module tb_wave_trace_gen;

  logic        pixel_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic        data_valid = 1'b0;
  logic [7:0]  trig_level = 8'd100;
  logic [7:0]  decim = 8'd0;
  logic        run = 1'b0;
  logic [10:0] pixel_xpos = 11'd2000;
  logic [10:0] pixel_ypos = 11'd2000;
  logic        pixel_flag, trig_auto, cap_busy;

  int checks = 0;
  int errors = 0;

  // Sample source: 0 none, 1 constant, 2 ramp, 3 square (50 low / 50 high)
  int          mode = 0;
  logic [7:0]  const_val = 8'd128;
  logic        gen_rst = 1'b0;
  int          gen_idx = 0;

  wave_trace_gen dut (
    .pixel_clk  (pixel_clk),
    .sys_rst_n  (sys_rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .trig_level (trig_level),
    .decim      (decim),
    .run        (run),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .pixel_flag (pixel_flag),
    .trig_auto  (trig_auto),
    .cap_busy   (cap_busy)
  );

  always #5 pixel_clk = ~pixel_clk;

  initial begin
    forever begin
      @(posedge pixel_clk);
      #2;
      if (gen_rst) begin
        gen_idx = 0;
        gen_rst = 1'b0;
      end
      case (mode)
        1:       begin data_valid = 1'b1; data_in = const_val; end
        2:       begin data_valid = 1'b1; data_in = 8'(gen_idx); end
        3:       begin data_valid = 1'b1; data_in = ((gen_idx % 100) < 50) ? 8'd0 : 8'd255; end
        default: begin data_valid = 1'b0; data_in = 8'd0; end
      endcase
      gen_idx++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic park();
    pixel_xpos = 11'd2000;
    pixel_ypos = 11'd2000;
  endtask

  task automatic frame();
    pixel_xpos = 11'd0;
    pixel_ypos = 11'd0;
    tick();
    park();
  endtask

  // Walk two columns up to x so the one-ahead read and prev_y are primed.
  task automatic probe(input string tag, input int x, input int y, input logic exp);
    pixel_ypos = 11'(y);
    pixel_xpos = 11'(x - 2);
    tick();
    pixel_xpos = 11'(x - 1);
    tick();
    pixel_xpos = 11'(x);
    @(negedge pixel_clk);
    check(tag, pixel_flag, exp);
    tick();
    park();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (cap_busy && n < budget) begin
      tick();
      n++;
    end
    check(tag, cap_busy, 1'b0);
  endtask

  task automatic restart(input int new_mode);
    run = 1'b0;
    tick();
    tick();
    mode    = new_mode;
    gen_rst = 1'b1;
    run     = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    repeat (3) tick();
    sys_rst_n = 1'b1;
    tick();

    // Reset state, idle frames
    check("rst_cap_busy", cap_busy, 1'b0);
    check("rst_trig_auto", trig_auto, 1'b0);
    frame();
    frame();
    probe("idle_flag_140_335", 140, 335, 1'b0);
    probe("idle_flag_640_335", 640, 335, 1'b0);
    probe("idle_flag_1139_624", 1139, 624, 1'b0);
    check("idle_cap_busy", cap_busy, 1'b0);

    // Constant 128 never crosses 100 upward: auto trigger after 2048 samples
    mode       = 1;
    const_val  = 8'd128;
    trig_level = 8'd100;
    run        = 1'b1;
    repeat (2030) tick();
    check("auto_not_early", trig_auto, 1'b0);
    check("auto_busy_waiting", cap_busy, 1'b1);
    for (int i = 0; i < 40 && !trig_auto; i++) tick();
    check("auto_fired", trig_auto, 1'b1);
    wait_idle("auto_capture_full", 1200);
    probe("auto_before_swap", 640, 335, 1'b0);
    frame();
    probe("const_140_335", 140, 335, 1'b1);
    probe("const_640_335", 640, 335, 1'b1);
    probe("const_1139_335", 1139, 335, 1'b1);
    probe("const_640_334", 640, 334, 1'b0);
    probe("const_640_336", 640, 336, 1'b0);
    probe("const_139_335", 139, 335, 1'b0);
    probe("const_1140_335", 1140, 335, 1'b0);

    // Ramp with level 128: capture starts at sample 128
    trig_level = 8'd128;
    restart(2);
    wait_idle("ramp_capture_full", 1500);
    frame();
    check("ramp_edge_trig", trig_auto, 1'b0);
    probe("ramp_140_335", 140, 335, 1'b1);
    probe("ramp_140_334", 140, 334, 1'b0);
    probe("ramp_141_333", 141, 333, 1'b1);
    probe("ramp_141_335", 141, 335, 1'b1);
    probe("ramp_141_332", 141, 332, 1'b0);
    probe("ramp_141_336", 141, 336, 1'b0);
    probe("ramp_wrap_268_400", 268, 400, 1'b1);
    probe("ramp_wrap_268_591", 268, 591, 1'b1);
    probe("ramp_wrap_268_592", 268, 592, 1'b0);

    // Square 0/255, period 100: transitions at columns 190, 240, ...
    restart(3);
    wait_idle("square_capture_full", 1500);
    frame();
    check("square_edge_trig", trig_auto, 1'b0);
    probe("square_140_81", 140, 81, 1'b1);
    probe("square_190_81", 190, 81, 1'b1);
    probe("square_190_300", 190, 300, 1'b1);
    probe("square_190_591", 190, 591, 1'b1);
    probe("square_190_80", 190, 80, 1'b0);
    probe("square_190_592", 190, 592, 1'b0);
    probe("square_191_300", 191, 300, 1'b0);
    probe("square_240_500", 240, 500, 1'b1);

    // Abort mid-capture: trace stays frozen across frames
    restart(2);
    repeat (400) tick();
    check("abort_busy_mid_capture", cap_busy, 1'b1);
    run = 1'b0;
    tick();
    tick();
    check("abort_cap_busy", cap_busy, 1'b0);
    for (int f = 0; f < 3; f++) begin
      frame();
      probe($sformatf("frozen_f%0d_190_300", f), 190, 300, 1'b1);
      probe($sformatf("frozen_f%0d_191_300", f), 191, 300, 1'b0);
    end
    gen_rst = 1'b1;
    run     = 1'b1;
    tick();
    tick();
    wait_idle("rerun_capture_full", 1500);
    frame();
    probe("rerun_141_333", 141, 333, 1'b1);
    probe("rerun_190_236", 190, 236, 1'b1);
    probe("rerun_190_300", 190, 300, 1'b0);

    // decim=3: every 4th ramp value (3, 7, ...), trigger on 127 -> 131
    run = 1'b0;
    tick();
    tick();
    decim   = 8'd3;
    mode    = 2;
    gen_rst = 1'b1;
    run     = 1'b1;
    tick();
    tick();
    wait_idle("decim_capture_full", 5000);
    frame();
    probe("decim_140_329", 140, 329, 1'b1);
    probe("decim_140_330", 140, 330, 1'b0);
    probe("decim_141_321", 141, 321, 1'b1);
    probe("decim_141_329", 141, 329, 1'b1);
    probe("decim_141_320", 141, 320, 1'b0);

    // Reset in the middle of the next capture
    repeat (1500) tick();
    check("reset_busy_mid_capture", cap_busy, 1'b1);
    pixel_ypos = 11'd325;
    pixel_xpos = 11'd139;
    tick();
    pixel_xpos = 11'd140;
    tick();
    pixel_xpos = 11'd141;
    @(negedge pixel_clk);
    check("reset_pre_flag", pixel_flag, 1'b1);
    tick();
    sys_rst_n  = 1'b0;
    pixel_xpos = 11'd142;
    pixel_ypos = 11'd317;
    @(negedge pixel_clk);
    check("reset_not_yet_sampled", pixel_flag, 1'b1);
    tick();
    pixel_xpos = 11'd143;
    pixel_ypos = 11'd310;
    @(negedge pixel_clk);
    check("reset_flag_cleared", pixel_flag, 1'b0);
    check("reset_cap_busy", cap_busy, 1'b0);
    check("reset_trig_auto", trig_auto, 1'b0);
    tick();
    sys_rst_n = 1'b1;
    park();
    tick();
    frame();
    probe("reset_no_swap_141_325", 141, 325, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
